// File: rtl/cv32e40p_apu_wb_buf.sv
// Purpose : APU result write-back buffer between the APU response channel and the
//           register-file APU write port; results wait in an in-order FIFO while
//           another writer owns the port.
// Latency : 0 cycles when the FIFO is empty and the port is free (bypass);
//           otherwise one write per free port cycle, oldest first.
// Backpressure: wb_port_busy_i holds the FIFO. stall_o asks the dispatcher to stop
//           issuing while enough room remains for the results it already has in flight.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   apu_rvalid_i/result/flags/waddr   incoming APU result
//   wb_port_busy_i          a higher-priority writer owns the write port this cycle
//   wb_we_o/waddr/wdata     register-file write port
//   fflags_we_o/fflags_o    flag update strobe and flags of the entry being written
//   stall_o                 dispatcher must not issue new APU requests
//   empty_o                 no buffered entries
//   read_regs_i/_valid_i    decode-stage source operands
//   pending_dep_o           a decode source matches a buffered destination
//
// Optional feature macro: CV32E40P_APU_WB_DEPCHK_EN
//   defined   -> pending_dep_o comparator network is built
//   undefined -> pending_dep_o tied 0; decode must wait for empty_o before reading
//                any APU destination register.

module cv32e40p_apu_wb_buf #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FLAG_W = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   apu_rvalid_i,
  input  logic [DATA_W-1:0]      apu_result_i,
  input  logic [FLAG_W-1:0]      apu_flags_i,
  input  logic [5:0]             apu_waddr_i,

  input  logic                   wb_port_busy_i,

  output logic                   wb_we_o,
  output logic [5:0]             wb_waddr_o,
  output logic [DATA_W-1:0]      wb_wdata_o,
  output logic                   fflags_we_o,
  output logic [FLAG_W-1:0]      fflags_o,

  output logic                   stall_o,
  output logic                   empty_o,

  input  logic [2:0][5:0]        read_regs_i,
  input  logic [2:0]             read_regs_valid_i,
  output logic                   pending_dep_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  // ---------------------------------------------------------------------------
  // Storage and bookkeeping state
  // ---------------------------------------------------------------------------
  logic [5:0]        waddr_q [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [FLAG_W-1:0] flags_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  logic has_entries;
  logic full;
  logic bypass;
  logic push;
  logic pop;
  logic we;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Control decisions for this cycle
  // ---------------------------------------------------------------------------
  assign has_entries = (count_q != '0);
  assign full        = (count_q == CNT_W'(DEPTH));

  // Head drains whenever the port is free.
  assign pop    = has_entries & ~wb_port_busy_i;
  // Only an empty buffer may forward the input directly; otherwise the new
  // result would overtake older buffered ones.
  assign bypass = apu_rvalid_i & ~has_entries & ~wb_port_busy_i;
  // A full buffer with the port held has nowhere to put a result: it is dropped.
  // When full and the port is free the head leaves this cycle, so the push fits.
  assign push   = apu_rvalid_i & ~bypass & ~(full & wb_port_busy_i);

  assign we     = (has_entries | apu_rvalid_i) & ~wb_port_busy_i;

  // ---------------------------------------------------------------------------
  // Write-port outputs: zero whenever nothing is written
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_we_o     = we;
    fflags_we_o = we;
    wb_waddr_o  = '0;
    wb_wdata_o  = '0;
    fflags_o    = '0;
    if (we) begin
      if (has_entries) begin
        wb_waddr_o = waddr_q[rd_ptr_q];
        wb_wdata_o = data_q[rd_ptr_q];
        fflags_o   = flags_q[rd_ptr_q];
      end else begin
        wb_waddr_o = apu_waddr_i;
        wb_wdata_o = apu_result_i;
        fflags_o   = apu_flags_i;
      end
    end
  end

  // Two results may already be in flight in the dispatcher when stall rises,
  // so stall from DEPTH-2 entries onward.
  assign stall_o = (count_q >= CNT_W'(DEPTH - 2)) |
                   ((count_q == CNT_W'(DEPTH - 1)) & apu_rvalid_i & wb_port_busy_i);

  assign empty_o = ~has_entries;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;

    if (pop) begin
      rd_ptr_d          = ptr_inc(rd_ptr_q);
      valid_d[rd_ptr_q] = 1'b0;
    end
    // Applied after the pop so that a full push+pop (wr_ptr == rd_ptr) leaves
    // the slot marked valid with the new entry.
    if (push) begin
      wr_ptr_d          = ptr_inc(wr_ptr_q);
      valid_d[wr_ptr_q] = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        waddr_q[e] <= '0;
        data_q[e]  <= '0;
        flags_q[e] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      if (push) begin
        waddr_q[wr_ptr_q] <= apu_waddr_i;
        data_q[wr_ptr_q]  <= apu_result_i;
        flags_q[wr_ptr_q] <= apu_flags_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-after-write dependency check against buffered destinations
  // ---------------------------------------------------------------------------
`ifdef CV32E40P_APU_WB_DEPCHK_EN
  logic dep;

  always_comb begin
    dep = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      // The head leaving this cycle has already reached the register file
      // by the time decode reads, so it no longer blocks.
      if (valid_q[e] && !(pop && (PTR_W'(e) == rd_ptr_q))) begin
        for (int i = 0; i < 3; i++) begin
          if (read_regs_valid_i[i] && (read_regs_i[i] == waddr_q[e])) begin
            dep = 1'b1;
          end
        end
      end
    end
    // A result being enqueued now is not yet in the register file either.
    if (push) begin
      for (int i = 0; i < 3; i++) begin
        if (read_regs_valid_i[i] && (read_regs_i[i] == apu_waddr_i)) begin
          dep = 1'b1;
        end
      end
    end
  end

  assign pending_dep_o = dep;
`else
  logic unused_depchk;
  assign unused_depchk = ^{read_regs_i, read_regs_valid_i, valid_q};
  assign pending_dep_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_wb_buf.sv
module tb_cv32e40p_apu_wb_buf;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int FLAG_W = 5;

  logic              clk_i;
  logic              rst_ni;
  logic              apu_rvalid_i;
  logic [DATA_W-1:0] apu_result_i;
  logic [FLAG_W-1:0] apu_flags_i;
  logic [5:0]        apu_waddr_i;
  logic              wb_port_busy_i;
  logic              wb_we_o;
  logic [5:0]        wb_waddr_o;
  logic [DATA_W-1:0] wb_wdata_o;
  logic              fflags_we_o;
  logic [FLAG_W-1:0] fflags_o;
  logic              stall_o;
  logic              empty_o;
  logic [2:0][5:0]   read_regs_i;
  logic [2:0]        read_regs_valid_i;
  logic              pending_dep_o;

  cv32e40p_apu_wb_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W), .FLAG_W(FLAG_W)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .apu_rvalid_i      (apu_rvalid_i),
    .apu_result_i      (apu_result_i),
    .apu_flags_i       (apu_flags_i),
    .apu_waddr_i       (apu_waddr_i),
    .wb_port_busy_i    (wb_port_busy_i),
    .wb_we_o           (wb_we_o),
    .wb_waddr_o        (wb_waddr_o),
    .wb_wdata_o        (wb_wdata_o),
    .fflags_we_o       (fflags_we_o),
    .fflags_o          (fflags_o),
    .stall_o           (stall_o),
    .empty_o           (empty_o),
    .read_regs_i       (read_regs_i),
    .read_regs_valid_i (read_regs_valid_i),
    .pending_dep_o     (pending_dep_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Reference model: an ordered list of buffered results.
  typedef struct {
    logic [5:0]        a;
    logic [DATA_W-1:0] d;
    logic [FLAG_W-1:0] f;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rv, input logic [5:0] a, input logic [31:0] d,
                        input logic [4:0] f, input logic bz);
    apu_rvalid_i   = rv;
    apu_waddr_i    = a;
    apu_result_i   = d;
    apu_flags_i    = f;
    wb_port_busy_i = bz;
  endtask

  // Called 1 time unit after a rising edge: check outputs mid-cycle against the
  // model for the currently driven inputs, then advance the model across the edge.
  task automatic cyc();
    int   n;
    logic drain, fwd, enq, e_we, e_stall, e_dep;
    logic [5:0]        e_a;
    logic [DATA_W-1:0] e_d;
    logic [FLAG_W-1:0] e_f;
    ent_t nw;
    #4;
    n     = q.size();
    drain = (n > 0) && !wb_port_busy_i;
    fwd   = apu_rvalid_i && (n == 0) && !wb_port_busy_i;
    enq   = apu_rvalid_i && !fwd && !((n == DEPTH) && wb_port_busy_i);
    if (apu_rvalid_i && wb_port_busy_i && (n == DEPTH))
      chk("overflow_stimulus", 64'd1, 64'd0);
    e_we = (n > 0 || apu_rvalid_i) && !wb_port_busy_i;
    e_a = '0; e_d = '0; e_f = '0;
    if (e_we) begin
      if (n > 0) begin e_a = q[0].a; e_d = q[0].d; e_f = q[0].f; end
      else begin e_a = apu_waddr_i; e_d = apu_result_i; e_f = apu_flags_i; end
    end
    e_stall = (n >= DEPTH - 2) || ((n == DEPTH - 1) && apu_rvalid_i && wb_port_busy_i);
    e_dep = 1'b0;
    for (int k = (drain ? 1 : 0); k < n; k++)
      for (int i = 0; i < 3; i++)
        if (read_regs_valid_i[i] && read_regs_i[i] == q[k].a) e_dep = 1'b1;
    if (enq)
      for (int i = 0; i < 3; i++)
        if (read_regs_valid_i[i] && read_regs_i[i] == apu_waddr_i) e_dep = 1'b1;
`ifndef CV32E40P_APU_WB_DEPCHK_EN
    e_dep = 1'b0;
`endif
    chk("wb_we",     64'(wb_we_o),     64'(e_we));
    chk("fflags_we", 64'(fflags_we_o), 64'(e_we));
    chk("wb_waddr",  64'(wb_waddr_o),  64'(e_a));
    chk("wb_wdata",  64'(wb_wdata_o),  64'(e_d));
    chk("fflags",    64'(fflags_o),    64'(e_f));
    chk("stall",     64'(stall_o),     64'(e_stall));
    chk("empty",     64'(empty_o),     64'(n == 0));
    chk("dep",       64'(pending_dep_o), 64'(e_dep));
    nw.a = apu_waddr_i; nw.d = apu_result_i; nw.f = apu_flags_i;
    @(posedge clk_i);
    if (drain) void'(q.pop_front());
    if (enq) q.push_back(nw);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    set_in(1'b0, 6'h0, 32'h0, 5'h0, 1'b0);
    read_regs_i = '0;
    read_regs_valid_i = '0;

    // Reset state
    #3;
    chk("rst_we",    64'(wb_we_o),       64'd0);
    chk("rst_empty", 64'(empty_o),       64'd1);
    chk("rst_stall", 64'(stall_o),       64'd0);
    chk("rst_dep",   64'(pending_dep_o), 64'd0);
    chk("rst_waddr", 64'(wb_waddr_o),    64'd0);
    #9 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Bypass into an empty buffer
    set_in(1'b1, 6'h05, 32'hDEADBEEF, 5'h03, 1'b0);
    cyc();
    set_in(1'b0, 6'h00, 32'h0, 5'h0, 1'b0);
    cyc();

    // Hold and fill: three results while the port is busy, then drain
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 6'(i), 32'h1000 + 32'(i), 5'(i), 1'b1);
      cyc();
    end
    chk("fill_count", 64'(q.size()), 64'd3);
    set_in(1'b0, 6'h0, 32'h0, 5'h0, 1'b0);
    repeat (4) cyc();

    // Simultaneous push and pop at count=2; address 7 retires last
    set_in(1'b1, 6'h11, 32'hA, 5'h0, 1'b1); cyc();
    set_in(1'b1, 6'h12, 32'hB, 5'h0, 1'b1); cyc();
    set_in(1'b1, 6'h07, 32'h77, 5'h1, 1'b0); cyc();
    chk("pushpop_count", 64'(q.size()), 64'd2);
    set_in(1'b0, 6'h0, 32'h0, 5'h0, 1'b0);
    repeat (3) cyc();

    // Dependency: buffered 0x0A, matched valid, matched invalid, draining head
    set_in(1'b1, 6'h0A, 32'h55, 5'h0, 1'b1); cyc();
    set_in(1'b0, 6'h0, 32'h0, 5'h0, 1'b1);
    read_regs_i[1] = 6'h0A; read_regs_valid_i = 3'b010; cyc();
    read_regs_valid_i = 3'b000; cyc();
    read_regs_valid_i = 3'b010; wb_port_busy_i = 1'b0; cyc();
    read_regs_valid_i = 3'b000;

    // Flags drained in order
    set_in(1'b1, 6'h08, 32'h1, 5'b00001, 1'b1); cyc();
    set_in(1'b1, 6'h09, 32'h2, 5'b10000, 1'b1); cyc();
    set_in(1'b0, 6'h0, 32'h0, 5'h0, 1'b0);
    repeat (3) cyc();

    // Reset mid-operation with three entries buffered
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 6'(20 + i), 32'($urandom), 5'(i), 1'b1);
      cyc();
    end
    set_in(1'b0, 6'h0, 32'h0, 5'h0, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_we",    64'(wb_we_o), 64'd0);
    chk("midrst_empty", 64'(empty_o), 64'd1);
    chk("midrst_stall", 64'(stall_o), 64'd0);
    q.delete();
    @(posedge clk_i); #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    repeat (3) cyc();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic bz, rv;
      bz = ($urandom_range(0, 2) == 0);
      rv = ($urandom_range(0, 1) == 1) && !((q.size() == DEPTH) && bz);
      set_in(rv, 6'($urandom_range(0, 7)), 32'($urandom), 5'($urandom), bz);
      for (int i = 0; i < 3; i++) read_regs_i[i] = 6'($urandom_range(0, 7));
      read_regs_valid_i = 3'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
